// File: rtl/io_output_buffer.sv
// io_output_buffer
// Captures every CPU output word (out/outFlag) into a small FIFO without ever
// stalling the core, then serializes each word MSB-first as bytes over a
// valid/ready stream. Reports occupancy and a sticky overflow flag for words
// that arrived while the FIFO was full and nothing was leaving.
module io_output_buffer #(
    parameter int WIDTH    = 24,
    parameter int DEPTH    = 8,
    parameter int PTRWIDTH = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                outFlag,
    input  logic [WIDTH-1:0]    out,
    input  logic                clearOverflow,
    input  logic                byteReady,
    output logic                byteValid,
    output logic [7:0]          byteData,
    output logic [PTRWIDTH:0]   fifoCount,
    output logic                fifoEmpty,
    output logic                fifoFull,
    output logic                overflow,
    output logic                busy
);

    localparam int BYTES = WIDTH / 8;
    localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [PTRWIDTH:0] DEPTH_C  = (PTRWIDTH + 1)'(DEPTH);
    localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(BYTES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [PTRWIDTH-1:0] r_wr_ptr;
    logic [PTRWIDTH-1:0] r_rd_ptr;
    logic [PTRWIDTH:0]   r_count;
    logic                r_overflow;
    logic [WIDTH-1:0]    r_shift;
    logic [IDXW-1:0]     r_byte_idx;

    logic                w_pop;
    logic                w_advance;
    logic                w_push;
    logic                w_drop;
    logic                w_overflow_nxt;

    // Serializer next-state: pop from IDLE, advance or chain words in SEND.
    // The chain decision uses the registered count, so a word written on the
    // same edge the last byte completes is picked up from IDLE a cycle later.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != {(PTRWIDTH + 1){1'b0}}) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_SEND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (byteReady) begin
                    if (r_byte_idx != LAST_IDX) begin
                        w_advance   = 1'b1;
                        w_state_nxt = ST_SEND;
                    end else if (r_count != {(PTRWIDTH + 1){1'b0}}) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Write acceptance: a full FIFO still takes a word when a pop frees a slot
    // on the same edge; otherwise the word is dropped and overflow latches.
    always_comb begin
        w_push = outFlag & ((r_count != DEPTH_C) | w_pop);
        w_drop = outFlag & ~w_push;
        if (w_drop) begin
            w_overflow_nxt = 1'b1;
        end else if (clearOverflow) begin
            w_overflow_nxt = 1'b0;
        end else begin
            w_overflow_nxt = r_overflow;
        end
    end

    // Serializer state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= {PTRWIDTH{1'b0}};
            r_rd_ptr   <= {PTRWIDTH{1'b0}};
            r_count    <= {(PTRWIDTH + 1){1'b0}};
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_overflow_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTRWIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTRWIDTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTRWIDTH + 1)'(1);
                2'b01:   r_count <= r_count - (PTRWIDTH + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= out;
        end
    end

    // Shift register: the current byte always sits in the top 8 bits, so a
    // finished word leaves its last byte visible while idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shift    <= {WIDTH{1'b0}};
            r_byte_idx <= {IDXW{1'b0}};
        end else if (w_pop) begin
            r_shift    <= r_mem[r_rd_ptr];
            r_byte_idx <= {IDXW{1'b0}};
        end else if (w_advance) begin
            r_shift    <= r_shift << 8;
            r_byte_idx <= r_byte_idx + IDXW'(1);
        end
    end

    assign byteValid = (r_state == ST_SEND);
    assign byteData  = r_shift[WIDTH-1 -: 8];
    assign fifoCount = r_count;
    assign fifoEmpty = (r_count == {(PTRWIDTH + 1){1'b0}});
    assign fifoFull  = (r_count == DEPTH_C);
    assign overflow  = r_overflow;
    assign busy      = (r_state != ST_IDLE) | (r_count != {(PTRWIDTH + 1){1'b0}});

endmodule

// File: tb/tb_io_output_buffer.sv
// Testbench for io_output_buffer: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_io_output_buffer;

    localparam int WIDTH    = 24;
    localparam int DEPTH    = 8;
    localparam int PTRWIDTH = 3;
    localparam int BYTES    = WIDTH / 8;

    logic                clock = 1'b0;
    logic                reset;
    logic                outFlag;
    logic [WIDTH-1:0]    out;
    logic                clearOverflow;
    logic                byteReady;
    logic                byteValid;
    logic [7:0]          byteData;
    logic [PTRWIDTH:0]   fifoCount;
    logic                fifoEmpty;
    logic                fifoFull;
    logic                overflow;
    logic                busy;

    io_output_buffer #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .PTRWIDTH (PTRWIDTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .outFlag       (outFlag),
        .out           (out),
        .clearOverflow (clearOverflow),
        .byteReady     (byteReady),
        .byteValid     (byteValid),
        .byteData      (byteData),
        .fifoCount     (fifoCount),
        .fifoEmpty     (fifoEmpty),
        .fifoFull      (fifoFull),
        .overflow      (overflow),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: words waiting in the FIFO, bytes still to be sent
    // for the word in the serializer, sticky overflow, last presented byte.
    logic [WIDTH-1:0] m_q[$];
    logic [7:0]       m_bytes[$];
    logic             m_ovf;
    logic [7:0]       m_data;

    task automatic m_reset();
        m_q.delete();
        m_bytes.delete();
        m_ovf  = 1'b0;
        m_data = 8'h00;
    endtask

    task automatic m_load();
        logic [WIDTH-1:0] w;
        w = m_q.pop_front();
        for (int b = 0; b < BYTES; b++) begin
            m_bytes.push_back(8'((w >> (WIDTH - 8 - 8 * b)) & 24'hFF));
        end
    endtask

    task automatic m_edge();
        int pre;
        bit popped;
        bit drop;
        logic [7:0] dummy;
        if (!reset) begin
            m_reset();
        end else begin
            pre    = m_q.size();
            popped = 1'b0;
            drop   = 1'b0;
            if (m_bytes.size() > 0) begin
                if (byteReady) begin
                    dummy = m_bytes.pop_front();
                    if (m_bytes.size() == 0 && pre > 0) begin
                        m_load();
                        popped = 1'b1;
                    end
                end
            end else if (pre > 0) begin
                m_load();
                popped = 1'b1;
            end
            if (outFlag) begin
                if (pre < DEPTH || popped) m_q.push_back(out);
                else drop = 1'b1;
            end
            if (drop) m_ovf = 1'b1;
            else if (clearOverflow) m_ovf = 1'b0;
            if (m_bytes.size() > 0) m_data = m_bytes[0];
        end
    endtask

    task automatic check_all();
        check_val("byteValid", 32'(byteValid), 32'(m_bytes.size() > 0));
        check_val("byteData",  32'(byteData),  32'(m_data));
        check_val("fifoCount", 32'(fifoCount), 32'(m_q.size()));
        check_val("fifoEmpty", 32'(fifoEmpty), 32'(m_q.size() == 0));
        check_val("fifoFull",  32'(fifoFull),  32'(m_q.size() == DEPTH));
        check_val("overflow",  32'(overflow),  32'(m_ovf));
        check_val("busy",      32'(busy),      32'((m_bytes.size() > 0) || (m_q.size() > 0)));
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic step();
        @(posedge clock);
        m_edge();
        #1;
        check_all();
    endtask

    task automatic write_words(input int n, input logic [WIDTH-1:0] base);
        for (int i = 0; i < n; i++) begin
            outFlag = 1'b1;
            out     = base + WIDTH'(i);
            step();
        end
        outFlag = 1'b0;
    endtask

    initial begin
        reset = 1'b0; outFlag = 1'b0; out = '0; clearOverflow = 1'b0; byteReady = 1'b0;
        m_reset();
        repeat (3) step();
        reset = 1'b1;
        step();

        // Single word
        byteReady = 1'b1;
        write_words(1, 24'hA1B2C3);
        repeat (6) step();
        check_val("single_idle_busy", 32'(busy), 32'h0);

        // Backpressure
        byteReady = 1'b0;
        write_words(1, 24'h123456);
        step();
        repeat (5) step();
        check_val("stall_hold", 32'(byteData), 32'h12);
        byteReady = 1'b1;
        repeat (5) step();

        // Back-to-back words
        write_words(4, 24'h000001);
        repeat (15) step();

        // Overflow and drain
        byteReady = 1'b0;
        write_words(10, 24'h000010);
        check_val("ovf_set", 32'(overflow), 32'h1);
        check_val("ovf_full", 32'(fifoFull), 32'h1);
        byteReady = 1'b1;
        repeat (32) step();
        clearOverflow = 1'b1; step(); clearOverflow = 1'b0; step();
        check_val("ovf_clear", 32'(overflow), 32'h0);

        // Clear on the same edge as a drop: set wins
        byteReady = 1'b0;
        write_words(9, 24'h000020);
        outFlag = 1'b1; out = 24'h000029; clearOverflow = 1'b1;
        step();
        outFlag = 1'b0; clearOverflow = 1'b0;
        check_val("ovf_set_wins", 32'(overflow), 32'h1);
        byteReady = 1'b1;
        repeat (32) step();
        clearOverflow = 1'b1; step(); clearOverflow = 1'b0;

        // Write while full with simultaneous pop
        byteReady = 1'b0;
        write_words(9, 24'h000040);
        byteReady = 1'b1;
        step(); step();
        outFlag = 1'b1; out = 24'hABCDEF;
        step();
        outFlag = 1'b0;
        check_val("full_pop_count", 32'(fifoCount), 32'(DEPTH));
        check_val("full_pop_ovf", 32'(overflow), 32'h0);
        repeat (32) step();

        // Async reset mid-word
        write_words(1, 24'hA1B2C3);
        step(); step(); step();
        #2 reset = 1'b0;
        #1;
        check_val("areset_valid", 32'(byteValid), 32'h0);
        check_val("areset_count", 32'(fifoCount), 32'h0);
        m_reset();
        step();
        reset = 1'b1;
        repeat (20) step();

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            outFlag       = ($urandom_range(0, 99) < 55);
            out           = WIDTH'($urandom);
            byteReady     = ($urandom_range(0, 99) < 70);
            clearOverflow = ($urandom_range(0, 99) < 5);
            reset         = ($urandom_range(0, 199) != 0);
            step();
        end
        reset = 1'b1; outFlag = 1'b0; clearOverflow = 1'b0; byteReady = 1'b1;
        repeat (40) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/io_output_buffer.md
Name: io_output_buffer

Overview:
- Sits directly downstream of the CPU I/O output (out, outFlag). Captures every word the CPU strobes out into a FIFO, without stalling the core.
- Serializes each buffered word into bytes, MSB first, over a valid/ready byte stream to the external sink (UART/host bridge).
- Reports FIFO occupancy and a sticky overflow flag.

Parameters:
WIDTH, 24, CPU output word width; must be a multiple of 8
DEPTH, 8, FIFO depth in words; power of two
PTRWIDTH, 3, log2(DEPTH)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
outFlag  input  1  CPU output strobe; one word per cycle while high
out  input  WIDTH  CPU output word, valid when outFlag=1
clearOverflow  input  1  synchronous clear of overflow
byteReady  input  1  sink ready
byteValid  output  1  byteData valid
byteData  output  8  current byte
fifoCount  output  PTRWIDTH+1  words held in FIFO (0..DEPTH)
fifoEmpty  output  1  fifoCount==0
fifoFull  output  1  fifoCount==DEPTH
overflow  output  1  sticky: a word was dropped
busy  output  1  FSM not in IDLE or FIFO non-empty

Behaviour:
- Reset (reset=0, async): pointers 0, fifoCount 0, fifoEmpty 1, fifoFull 0, overflow 0, byteValid 0, byteData 0, busy 0, FSM IDLE, shift register 0. Reset mid-transfer discards the FIFO contents and the partial word; no byte is emitted after reset releases until a new outFlag.
- BYTES = WIDTH/8 (3 at default).
- FIFO write: at an edge with outFlag=1, the word is accepted if fifoCount<DEPTH, or if a pop occurs on the same edge. Otherwise the word is dropped and overflow is set.
- overflow: stays set until an edge with clearOverflow=1. A drop on the same edge as clearOverflow leaves overflow=1 (set wins).
- fifoCount: +1 on write only, -1 on pop only, unchanged on a simultaneous write and pop. Pointers wrap modulo DEPTH.
- FSM states: IDLE, SEND.
  - IDLE: byteValid=0. If fifoEmpty=0, pop the head into the shift register, set byteIndex=0, go to SEND.
  - SEND: byteValid=1. byteData = shift register bits [WIDTH-1-8*byteIndex -: 8]. Held stable while byteValid=1 and byteReady=0.
  - On a SEND edge with byteReady=1 and byteIndex<BYTES-1: byteIndex+1.
  - On a SEND edge with byteReady=1 and byteIndex=BYTES-1: if the FIFO is non-empty (registered count before this edge), pop the next word, set byteIndex=0, stay in SEND with no bubble. Otherwise go to IDLE.
  - A word written on the same edge the last byte completes is not visible to this decision. It is popped from IDLE one cycle later.
- Latency: with FIFO empty and FSM idle, outFlag sampled at edge t0 gives fifoCount=1 after t0. Pop occurs at t0+1, and byteValid=1 with the first byte after t0+1. Throughput with byteReady tied high is one byte per cycle, continuous across words.
- byteData keeps its last value in IDLE; only byteValid qualifies it.
- All outputs are registered except fifoEmpty, fifoFull and busy, which decode registered state.

Test Plan:
- Single word: reset released, one outFlag cycle with out=0xA1B2C3, byteReady=1 -> byteValid high for exactly 3 cycles starting 2 edges after the write with bytes A1,B2,C3; then IDLE, fifoCount=0, busy=0.
- Backpressure: word 0x123456, byteReady=0 for 5 cycles after byteValid rises, then 1 -> byteData holds 0x12 throughout the stall; the sequence 12,34,56 completes with no byte repeated or lost.
- Back-to-back: 4 consecutive outFlag cycles (0x000001..0x000004), byteReady=1 -> 12 consecutive valid bytes 00,00,01,00,00,02,...,04 with no idle cycle between words.
- Overflow: byteReady=0, 10 consecutive outFlag cycles with 0x10..0x19 -> after word 1 is popped into the serializer the FIFO holds 8 words, fifoFull=1, and the final word 0x19 is dropped with overflow=1. Release byteReady -> exactly 9 words drain, in order. clearOverflow pulse -> overflow=0; clearOverflow on the same edge as a drop -> overflow stays 1.
- Write while full with pop: FIFO full and the last byte of the current word accepted on the same edge as outFlag=1 with 0xABCDEF -> word accepted, fifoCount stays DEPTH, overflow stays 0, 0xABCDEF is emitted last.
- Async reset mid-word: reset=0 asserted between edges after byte 2 of 0xA1B2C3 -> byteValid=0 and fifoCount=0 immediately. After release with no new outFlag, no bytes are emitted for 20 cycles.
